// File: rtl/pose_iter_ctrl.sv
// Coarse-to-fine pose refinement sequencer: walks pyramid levels from coarsest to
// finest, alternating delta-pose solves and pose updates until convergence or limit.
module pose_iter_ctrl #(
  parameter  int POSE_BW   = 42,
  parameter  int NUM_LEVEL = 3,
  parameter  int ITER_BW   = 4,
  localparam int LVL_BW    = (NUM_LEVEL > 1) ? $clog2(NUM_LEVEL) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [11:0][POSE_BW-1:0]          i_init_pose,
  input  logic [NUM_LEVEL-1:0][ITER_BW-1:0] i_iter_max,
  output logic                              o_solve_start,
  output logic [LVL_BW-1:0]                 o_level,
  input  logic                              i_solve_done,
  input  logic                              i_converged,
  output logic                              o_upd_start,
  input  logic                              i_upd_done,
  input  logic [11:0][POSE_BW-1:0]          i_upd_pose,
  output logic [11:0][POSE_BW-1:0]          o_pose,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [7:0]                        o_iter_total
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOLVE,
    S_WAIT_SOLVE,
    S_UPDATE,
    S_WAIT_UPDATE,
    S_NEXT_LEVEL,
    S_DONE
  } state_t;

  state_t                              state_q, state_d;
  logic [11:0][POSE_BW-1:0]            pose_q;
  logic [NUM_LEVEL-1:0][ITER_BW-1:0]   iter_max_q;
  logic [LVL_BW-1:0]                   level_q;
  logic [LVL_BW-1:0]                   level_dn;
  logic [ITER_BW-1:0]                  iter_cnt_q;
  logic [7:0]                          iter_total_q;
  logic                                iter_last;
  logic                                start_acc;
  logic                                upd_acc;
  logic                                lvl_dec;

  assign level_dn  = level_q - LVL_BW'(1);
  assign iter_last = ({1'b0, iter_cnt_q} + (ITER_BW+1)'(1)) == {1'b0, iter_max_q[level_q]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    upd_acc   = 1'b0;
    lvl_dec   = 1'b0;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            start_acc = 1'b1;
            // A level with a zero iteration budget is skipped without a solve.
            state_d   = (i_iter_max[NUM_LEVEL-1] == '0) ? S_NEXT_LEVEL : S_SOLVE;
          end
        end
        S_SOLVE:      state_d = S_WAIT_SOLVE;
        S_WAIT_SOLVE: begin
          if (i_solve_done) state_d = i_converged ? S_NEXT_LEVEL : S_UPDATE;
        end
        S_UPDATE:     state_d = S_WAIT_UPDATE;
        S_WAIT_UPDATE: begin
          if (i_upd_done) begin
            upd_acc = 1'b1;
            state_d = iter_last ? S_NEXT_LEVEL : S_SOLVE;
          end
        end
        S_NEXT_LEVEL: begin
          if (level_q == '0) begin
            state_d = S_DONE;
          end else begin
            lvl_dec = 1'b1;
            state_d = (iter_max_q[level_dn] == '0) ? S_NEXT_LEVEL : S_SOLVE;
          end
        end
        S_DONE:       state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Abort suppresses the pulses in the same cycle it is seen.
  always_comb begin
    o_solve_start = (state_q == S_SOLVE)  && !i_abort;
    o_upd_start   = (state_q == S_UPDATE) && !i_abort;
    o_done        = (state_q == S_DONE)   && !i_abort;
    o_busy        = (state_q != S_IDLE);
  end

  // NOTE: the pose words are an architecturally visible output, so they are
  // reset like any other register rather than left as uninitialised storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pose_q       <= '0;
      iter_max_q   <= '0;
      level_q      <= '0;
      iter_cnt_q   <= '0;
      iter_total_q <= '0;
    end else if (start_acc) begin
      pose_q       <= i_init_pose;
      iter_max_q   <= i_iter_max;
      level_q      <= LVL_BW'(NUM_LEVEL - 1);
      iter_cnt_q   <= '0;
      iter_total_q <= '0;
    end else if (upd_acc) begin
      pose_q     <= i_upd_pose;
      iter_cnt_q <= iter_cnt_q + ITER_BW'(1);
      if (iter_total_q != 8'hFF) iter_total_q <= iter_total_q + 8'd1;
    end else if (lvl_dec) begin
      level_q    <= level_dn;
      iter_cnt_q <= '0;
    end
  end

  assign o_pose       = pose_q;
  assign o_level      = level_q;
  assign o_iter_total = iter_total_q;

endmodule

// File: tb/tb_pose_iter_ctrl.sv
// Directed bench for pose_iter_ctrl: frame sequencing, level skipping, stray
// completions, abort and asynchronous reset.
module tb_pose_iter_ctrl;

  localparam int PB = 42;
  localparam int NL = 3;
  localparam int IB = 4;
  localparam int LB = 2;

  typedef logic [11:0][PB-1:0] pose_t;
  typedef logic [NL-1:0][IB-1:0] imax_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  pose_t         i_init_pose = '0;
  imax_t         i_iter_max = '0;
  logic          o_solve_start;
  logic [LB-1:0] o_level;
  logic          i_solve_done = 1'b0;
  logic          i_converged = 1'b0;
  logic          o_upd_start;
  logic          i_upd_done = 1'b0;
  pose_t         i_upd_pose = '0;
  pose_t         o_pose;
  logic          o_busy;
  logic          o_done;
  logic [7:0]    o_iter_total;

  pose_iter_ctrl #(.POSE_BW(PB), .NUM_LEVEL(NL), .ITER_BW(IB)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_init_pose(i_init_pose), .i_iter_max(i_iter_max),
    .o_solve_start(o_solve_start), .o_level(o_level),
    .i_solve_done(i_solve_done), .i_converged(i_converged),
    .o_upd_start(o_upd_start), .i_upd_done(i_upd_done), .i_upd_pose(i_upd_pose),
    .o_pose(o_pose), .o_busy(o_busy), .o_done(o_done), .o_iter_total(o_iter_total)
  );

  always #5 i_clk = ~i_clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_solve = 0;
  int          n_upd = 0;
  int          n_done = 0;
  logic [15:0] lvl_hist = '0;
  logic        both_hi = 1'b0;

  always @(posedge i_clk) begin
    if (o_solve_start) begin
      n_solve  <= n_solve + 1;
      lvl_hist <= {lvl_hist[13:0], o_level};
    end
    if (o_upd_start) n_upd <= n_upd + 1;
    if (o_done) n_done <= n_done + 1;
    if (o_solve_start && o_upd_start) both_hi <= 1'b1;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic pose_t pat(input int base);
    pose_t p;
    for (int k = 0; k < 12; k++) p[k] = PB'(base + k);
    return p;
  endfunction

  function automatic pose_t ident();
    pose_t p = '0;
    p[0]  = PB'(16777216);
    p[5]  = PB'(16777216);
    p[10] = PB'(16777216);
    return p;
  endfunction

  task automatic start_frame(input imax_t im, input pose_t ip);
    i_iter_max  = im;
    i_init_pose = ip;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  // Models solver and update block: each answers 5 cycles after its start pulse.
  task automatic run_frame(input logic conv, input pose_t up, input int budget,
                           output logic got_done);
    int sd = -1;
    int ud = -1;
    got_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      i_solve_done = 1'b0;
      i_upd_done   = 1'b0;
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
      if (o_solve_start) sd = 4;
      else if (sd > 0) sd--;
      if (o_upd_start) ud = 4;
      else if (ud > 0) ud--;
      if (sd == 0) begin
        i_solve_done = 1'b1;
        i_converged  = conv;
        sd = -1;
      end
      if (ud == 0) begin
        i_upd_done = 1'b1;
        i_upd_pose = up;
        ud = -1;
      end
      tick();
    end
    i_solve_done = 1'b0;
    i_upd_done   = 1'b0;
  endtask

  int   s0, u0, d0;
  logic ok;

  initial begin
    // Reset state
    #1;
    check("rst_busy", 512'(o_busy), 512'(0));
    check("rst_pose", 512'(o_pose), 512'(0));
    check("rst_level", 512'(o_level), 512'(0));
    check("rst_total", 512'(o_iter_total), 512'(0));
    check("rst_pulses", 512'({o_solve_start, o_upd_start, o_done}), 512'(0));
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    tick();

    // Never converging, two iterations per level
    s0 = n_solve; u0 = n_upd; d0 = n_done;
    start_frame({4'd2, 4'd2, 4'd2}, ident());
    check("f1_busy", 512'(o_busy), 512'(1));
    check("f1_level", 512'(o_level), 512'(2));
    run_frame(1'b0, pat(100), 500, ok);
    check("f1_done_seen", 512'(ok), 512'(1));
    check("f1_solves", 512'(n_solve - s0), 512'(6));
    check("f1_upds", 512'(n_upd - u0), 512'(6));
    check("f1_levels", 512'(lvl_hist[11:0]), 512'(12'hA50));
    check("f1_total", 512'(o_iter_total), 512'(6));
    check("f1_pose", 512'(o_pose), 512'(pat(100)));
    tick();
    check("f1_one_done", 512'(n_done - d0), 512'(1));
    check("f1_idle", 512'(o_busy), 512'(0));
    check("f1_pose_hold", 512'(o_pose), 512'(pat(100)));

    // Converges on first solve of every level
    s0 = n_solve; u0 = n_upd; d0 = n_done;
    start_frame({4'd3, 4'd3, 4'd3}, ident());
    run_frame(1'b1, pat(200), 500, ok);
    tick();
    check("f2_done_seen", 512'(ok), 512'(1));
    check("f2_solves", 512'(n_solve - s0), 512'(3));
    check("f2_upds", 512'(n_upd - u0), 512'(0));
    check("f2_levels", 512'(lvl_hist[5:0]), 512'(6'h24));
    check("f2_pose", 512'(o_pose), 512'(ident()));
    check("f2_total", 512'(o_iter_total), 512'(0));
    check("f2_one_done", 512'(n_done - d0), 512'(1));

    // Zero-budget levels skipped: only level 1 runs
    s0 = n_solve; u0 = n_upd; d0 = n_done;
    start_frame({4'd0, 4'd1, 4'd0}, ident());
    run_frame(1'b0, pat(100), 500, ok);
    tick();
    check("f3_done_seen", 512'(ok), 512'(1));
    check("f3_solves", 512'(n_solve - s0), 512'(1));
    check("f3_level", 512'(lvl_hist[1:0]), 512'(1));
    check("f3_upds", 512'(n_upd - u0), 512'(1));
    check("f3_total", 512'(o_iter_total), 512'(1));
    check("f3_one_done", 512'(n_done - d0), 512'(1));

    // Stray update completion while waiting on the solver
    start_frame({4'd1, 4'd1, 4'd1}, pat(500));
    tick();
    i_upd_done = 1'b1;
    i_upd_pose = pat(900);
    tick();
    i_upd_done = 1'b0;
    check("stray_pose", 512'(o_pose), 512'(pat(500)));
    check("stray_total", 512'(o_iter_total), 512'(0));
    i_solve_done = 1'b1;
    i_converged  = 1'b0;
    tick();
    i_solve_done = 1'b0;
    check("upd_pulse", 512'({o_upd_start, o_solve_start}), 512'(2'b10));
    tick();
    i_upd_done = 1'b1;
    i_upd_pose = pat(100);
    tick();
    i_upd_done = 1'b0;
    check("upd_pose", 512'(o_pose), 512'(pat(100)));
    check("upd_total", 512'(o_iter_total), 512'(1));
    run_frame(1'b0, pat(100), 500, ok);
    check("f4_done_seen", 512'(ok), 512'(1));
    check("f4_total", 512'(o_iter_total), 512'(3));
    tick();

    // Abort in WAIT_UPDATE after one completed iteration
    d0 = n_done;
    start_frame({4'd2, 4'd2, 4'd2}, ident());
    tick();
    i_solve_done = 1'b1;
    i_converged  = 1'b0;
    tick();
    i_solve_done = 1'b0;
    tick();
    i_upd_done = 1'b1;
    i_upd_pose = pat(300);
    tick();
    i_upd_done = 1'b0;
    check("ab_total_pre", 512'(o_iter_total), 512'(1));
    tick();
    i_solve_done = 1'b1;
    tick();
    i_solve_done = 1'b0;
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("ab_idle", 512'(o_busy), 512'(0));
    check("ab_pose_kept", 512'(o_pose), 512'(pat(300)));
    tick();
    check("ab_no_done", 512'(n_done - d0), 512'(0));
    start_frame({4'd2, 4'd2, 4'd2}, pat(600));
    check("ab_restart_lvl", 512'(o_level), 512'(2));
    check("ab_restart_tot", 512'(o_iter_total), 512'(0));
    check("ab_restart_pose", 512'(o_pose), 512'(pat(600)));
    check("ab_restart_ss", 512'(o_solve_start), 512'(1));

    // Abort in SOLVE masks the start pulse
    i_abort = 1'b1;
    #1;
    check("ab_mask_ss", 512'(o_solve_start), 512'(0));
    tick();
    i_abort = 1'b0;
    check("ab2_idle", 512'(o_busy), 512'(0));
    check("ab2_no_done", 512'(n_done - d0), 512'(0));
    tick();

    // Start ignored while busy, then asynchronous reset mid-frame
    start_frame({4'd1, 4'd1, 4'd1}, ident());
    tick();
    i_iter_max  = {4'd0, 4'd0, 4'd0};
    i_init_pose = pat(700);
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
    check("busy_start_pose", 512'(o_pose), 512'(ident()));
    check("busy_start_ss", 512'(o_solve_start), 512'(0));
    check("busy_start_busy", 512'(o_busy), 512'(1));
    #3 i_rst_n = 1'b0;
    #1;
    check("arst_busy", 512'(o_busy), 512'(0));
    check("arst_pose", 512'(o_pose), 512'(0));
    check("arst_level", 512'(o_level), 512'(0));
    check("arst_pulses", 512'({o_solve_start, o_upd_start, o_done}), 512'(0));
    #2 i_rst_n = 1'b1;
    tick();
    check("arst_stays_idle", 512'(o_busy), 512'(0));
    check("pulse_excl", 512'(both_hi), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pose_iter_ctrl.md
POSE_ITER_CTRL -- requirements
Module: pose_iter_ctrl

Interface
REQ-001 SHALL have parameter POSE_BW, default 42: pose element width, signed Q(POSE_BW-24).24.
REQ-002 SHALL have parameter NUM_LEVEL, default 3: number of pyramid levels.
REQ-003 SHALL have parameter ITER_BW, default 4: per-level iteration limit width.
REQ-004 i_clk  input  1  single clock, all state on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_start  input  1  one-cycle pulse, begins a frame when idle.
REQ-007 i_abort  input  1  synchronous abort, returns to IDLE.
REQ-008 i_init_pose  input  12 x POSE_BW  initial pose, sampled on accepted i_start.
REQ-009 i_iter_max  input  NUM_LEVEL x ITER_BW  iteration limit per level, sampled on accepted i_start.
REQ-010 o_solve_start  output  1  one-cycle pulse launching the delta-pose solver.
REQ-011 o_level  output  $clog2(NUM_LEVEL)  current pyramid level for the solver.
REQ-012 i_solve_done  input  1  solver completion pulse.
REQ-013 i_converged  input  1  solver convergence flag, valid only with i_solve_done.
REQ-014 o_upd_start  output  1  one-cycle pulse to the pose-update block.
REQ-015 i_upd_done  input  1  pose-update completion pulse.
REQ-016 i_upd_pose  input  12 x POSE_BW  updated pose, valid with i_upd_done.
REQ-017 o_pose  output  12 x POSE_BW  current pose register, also fed to solver and update block.
REQ-018 o_busy  output  1  high in any state other than IDLE.
REQ-019 o_done  output  1  one-cycle frame-complete pulse.
REQ-020 o_iter_total  output  8  iterations completed this frame, saturating at 255.

Function
REQ-021 SHALL implement states IDLE, SOLVE, WAIT_SOLVE, UPDATE, WAIT_UPDATE, NEXT_LEVEL, DONE.
REQ-022 IDLE: i_start=1 SHALL load pose_r<=i_init_pose, latch i_iter_max, set level=NUM_LEVEL-1, clear iter_cnt and o_iter_total, and go to NEXT_LEVEL check via SOLVE entry rule (REQ-029).
REQ-023 SOLVE: SHALL assert o_solve_start for exactly one cycle, then go to WAIT_SOLVE.
REQ-024 WAIT_SOLVE: on i_solve_done with i_converged=1 SHALL go to NEXT_LEVEL with no update.
REQ-025 WAIT_SOLVE: on i_solve_done with i_converged=0 SHALL go to UPDATE.
REQ-026 UPDATE: SHALL assert o_upd_start for exactly one cycle, then go to WAIT_UPDATE.
REQ-027 WAIT_UPDATE: on i_upd_done SHALL load pose_r<=i_upd_pose, increment iter_cnt and o_iter_total (saturating), then go to NEXT_LEVEL if iter_cnt+1==iter_max[level], else SOLVE.
REQ-028 NEXT_LEVEL: level==0 SHALL go to DONE; else level decrements, iter_cnt clears, entry rule applies.
REQ-029 Entry rule: a level with iter_max==0 SHALL be skipped with no o_solve_start (goes directly to NEXT_LEVEL).
REQ-030 DONE: SHALL assert o_done for one cycle, return to IDLE; o_pose holds final pose until next accepted i_start.
REQ-031 i_start while o_busy=1 SHALL be ignored.
REQ-032 i_solve_done/i_upd_done outside their wait state SHALL be ignored.
REQ-033 i_abort SHALL have priority over all transitions: next state IDLE, no o_done, pose_r retained, no start pulse that cycle.
REQ-034 o_level SHALL equal the level register; o_solve_start and o_upd_start SHALL never be high together.
REQ-035 Pose words SHALL be stored unmodified, no arithmetic on pose data.

Reset
REQ-036 On i_rst_n=0: state IDLE, pose_r all 0, level 0, iter_cnt 0, o_iter_total 0, o_solve_start/o_upd_start/o_done/o_busy 0, mid-frame included.

Verification
REQ-037 iter_max={2,2,2}, never converged, solver/update done 5 cycles after start -> 6 solve and 6 upd pulses, o_level 2,2,1,1,0,0, o_iter_total=6, one o_done.
REQ-038 iter_max={3,3,3}, i_converged=1 on first solve each level -> 3 solve pulses, 0 upd pulses, pose_r==i_init_pose (diag 16777216), o_iter_total=0.
REQ-039 iter_max={0,1,0} (level 2,1,0 order: level1=1) -> exactly one solve at o_level=1, o_done follows.
REQ-040 i_upd_pose words 0..11 = 100..111 -> o_pose matches the cycle after i_upd_done; stray i_upd_done in WAIT_SOLVE leaves pose unchanged.
REQ-041 i_abort in WAIT_UPDATE, then i_start -> IDLE next cycle, no o_done, new frame restarts at level 2 with o_iter_total=0.
REQ-042 i_rst_n low during WAIT_SOLVE -> all outputs at reset values immediately; i_start during busy ignored.
